// File: rtl/audio_test_path.sv
// Per-channel audio sample processor: source select (ADC or sawtooth/triangle/square
// generator), saturating fixed-point gain, and a peak-hold level meter with decay.
module audio_test_path #(
  parameter int DW          = 18,
  parameter int NCH         = 2,
  parameter int GW          = 8,
  parameter int FRAC        = 0,
  parameter int MB          = 8,
  parameter int DECAY_SHIFT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [NCH*DW-1:0]   adc_in,
  input  logic [2*NCH-1:0]    mode,
  input  logic [DW-1:0]       step,
  input  logic                gain_en,
  input  logic [GW-1:0]       gain,
  output logic [NCH*DW-1:0]   dac_out,
  output logic                out_valid,
  output logic [MB-1:0]       meter
);

  localparam int PW = DW + GW + 1;
  localparam int LG = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int SW = DW + LG;

  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};

  function automatic logic signed [DW-1:0] gen_sample(input logic [1:0] m,
                                                     input logic [DW-1:0] ph,
                                                     input logic signed [DW-1:0] adc);
    logic [DW-2:0] t;
    logic signed [DW-1:0] r;
    t = ph[DW-1] ? ~ph[DW-2:0] : ph[DW-2:0];
    case (m)
      2'd0:    r = adc;
      2'd1:    r = $signed(ph);
      2'd2:    r = $signed({t, 1'b0} ^ S_MIN);
      default: r = ph[DW-1] ? S_MIN : S_MAX;
    endcase
    return r;
  endfunction

  // Full-precision product, then shift and clamp into the sample range.
  function automatic logic signed [DW-1:0] sat_gain(input logic signed [DW-1:0] x,
                                                   input logic [GW-1:0] g);
    logic signed [PW-1:0] p;
    logic signed [DW-1:0] r;
    p = PW'(x) * $signed({{(PW-GW){1'b0}}, g});
    p = p >>> FRAC;
    if (p > P_MAX)      r = S_MAX;
    else if (p < P_MIN) r = S_MIN;
    else                r = p[DW-1:0];
    return r;
  endfunction

  // Magnitude with the most negative value folded onto full scale.
  function automatic logic [DW-2:0] abs_sat(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] n;
    logic [DW-2:0] r;
    n = -x;
    if (x == S_MIN)   r = S_MAX[DW-2:0];
    else if (x[DW-1]) r = n[DW-2:0];
    else              r = x[DW-2:0];
    return r;
  endfunction

  logic [DW-1:0]        phase;
  logic                 vld_p0, vld_p1;
  logic signed [DW-1:0] sel_p0 [NCH];
  logic                 gain_en_p0;
  logic [GW-1:0]        gain_p0;
  logic [DW-2:0]        peak_p2;

  logic signed [SW-1:0] sum;
  logic signed [DW-1:0] mono;
  logic [DW-2:0]        lvl;
  logic [DW-2:0]        peak_nxt;

  assign out_valid = vld_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (sample_en) phase <= phase + step + 1'b1;
      vld_p0 <= sample_en;
      vld_p1 <= vld_p0;
    end
  end

  // Stage 1: source select and control capture
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) sel_p0[k] <= '0;
      gain_en_p0 <= 1'b0;
      gain_p0    <= '0;
    end else if (sample_en) begin
      for (int k = 0; k < NCH; k++)
        sel_p0[k] <= gen_sample(mode[2*k +: 2], phase, $signed(adc_in[k*DW +: DW]));
      gain_en_p0 <= gain_en;
      gain_p0    <= gain;
    end
  end

  // Stage 2: gain and saturation
  always_ff @(posedge clock) begin
    if (reset) begin
      dac_out <= '0;
    end else if (vld_p0) begin
      for (int k = 0; k < NCH; k++)
        dac_out[k*DW +: DW] <= gain_en_p0 ? sat_gain(sel_p0[k], gain_p0) : sel_p0[k];
    end
  end

  // Stage 3: mono mix, peak hold with exponential decay
  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++)
      sum = sum + SW'($signed(dac_out[k*DW +: DW]));
    mono     = DW'(sum >>> LG);
    lvl      = abs_sat(mono);
    peak_nxt = (lvl > peak_p2) ? lvl : peak_p2 - (peak_p2 >> DECAY_SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_p2 <= '0;
      meter   <= '0;
    end else if (vld_p1) begin
      peak_p2 <= peak_nxt;
      meter   <= peak_nxt[DW-2 -: MB];
    end
  end

endmodule

// File: tb/tb_audio_test_path.sv
// Self-checking bench for audio_test_path: scoreboard of expected DAC samples
// plus directed meter, reset and throughput sequences.
module tb_audio_test_path;
  localparam int DW  = 18;
  localparam int NCH = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              sample_en;
  logic [NCH*DW-1:0] adc_in;
  logic [2*NCH-1:0]  mode;
  logic [DW-1:0]     step;
  logic              gain_en;
  logic [7:0]        gain;
  logic [NCH*DW-1:0] dac_out;
  logic              out_valid;
  logic [7:0]        meter;

  always #5 clock = ~clock;

  audio_test_path dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .adc_in(adc_in),
    .mode(mode), .step(step), .gain_en(gain_en), .gain(gain),
    .dac_out(dac_out), .out_valid(out_valid), .meter(meter)
  );

  typedef struct {int e0; int e1; int stamp;} exp_t;
  typedef struct {bit ge; int g; int a0; int a1; int e0; int e1;} vec_t;

  exp_t q[$];
  vec_t vt[7];
  int tri_exp[9];
  int checks = 0, errors = 0, cyc = 0, run = 0, max_run = 0, vcount = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic signed [DW-1:0] d0, d1;
    @(posedge clock);
    #1;
    cyc++;
    if (out_valid) begin
      vcount++;
      run++;
      if (run > max_run) max_run = run;
      d0 = dac_out[DW-1:0];
      d1 = dac_out[2*DW-1:DW];
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("dac_ch0", int'(d0), e.e0);
        chk("dac_ch1", int'(d1), e.e1);
        chk("latency", cyc - e.stamp, 2);
      end
    end else run = 0;
  endtask

  task automatic strobe(input int a0, input int a1, input bit push, input int e0, input int e1);
    exp_t e;
    sample_en = 1'b1;
    adc_in = {DW'(a1), DW'(a0)};
    if (push) begin
      e.e0 = e0; e.e1 = e1; e.stamp = cyc;
      q.push_back(e);
    end
    tick();
    sample_en = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 4,   1000,    -7,      4000,    -28};
    vt[1] = '{1'b1, 4,   50000,   -50000,  131071,  -131072};
    vt[2] = '{1'b0, 4,   50000,   3,       50000,   3};
    vt[3] = '{1'b1, 0,   12345,   -12345,  0,       0};
    vt[4] = '{1'b1, 255, -1,      513,     -255,    130815};
    vt[5] = '{1'b1, 1,   -131072, 131071,  -131072, 131071};
    vt[6] = '{1'b1, 2,   65536,   -65536,  131071,  -131072};
    tri_exp = '{-131072, -98304, -65536, -32768, 0, 32768, 65536, 98304, 131070};

    reset = 1'b1; sample_en = 1'b1; adc_in = {DW'(5000), DW'(5000)};
    mode = '0; step = '0; gain_en = 1'b0; gain = '0;
    repeat (3) begin
      tick();
      chk("rst_dac", int'(|dac_out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_meter", int'(meter), 0);
    end
    reset = 1'b0; sample_en = 1'b0;
    vcount = 0;
    repeat (10) tick();
    chk("idle_valid_count", vcount, 0);

    // Latency and pulse width for a single sample
    mode = '0; step = DW'(4095); gain_en = 1'b1; gain = 8'd4;
    strobe(1000, 0, 1'b1, 4000, 0);
    chk("valid_at_n1", int'(out_valid), 0);
    tick();
    chk("valid_at_n2", int'(out_valid), 1);
    tick();
    chk("valid_at_n3", int'(out_valid), 0);
    drain();

    // Gain/saturation vectors, back to back
    for (int i = 0; i < 7; i++) begin
      gain_en = vt[i].ge;
      gain = 8'(vt[i].g);
      strobe(vt[i].a0, vt[i].a1, 1'b1, vt[i].e0, vt[i].e1);
    end
    drain();

    // Sawtooth on ch0, square on ch1, 64 consecutive strobes
    do_reset();
    mode = 4'b1101; step = DW'(4095); gain_en = 1'b0;
    max_run = 0;
    for (int k = 0; k < 64; k++)
      strobe(0, 0, 1'b1, (k < 32) ? k * 4096 : (k - 64) * 4096, (k < 32) ? 131071 : -131072);
    drain();
    chk("consecutive_valid", max_run, 64);

    // Triangle on ch0, square on ch1
    do_reset();
    mode = 4'b1110; step = DW'(16383);
    for (int k = 0; k < 9; k++)
      strobe(0, 0, 1'b1, tri_exp[k], (k < 8) ? 131071 : -131072);
    drain();

    // Meter attack, decay, hold and negative full scale
    do_reset();
    mode = '0; gain_en = 1'b0;
    strobe(131071, 131071, 1'b1, 131071, 131071);
    chk("meter_n1", int'(meter), 0);
    tick();
    chk("meter_n2", int'(meter), 0);
    tick();
    chk("meter_peak", int'(meter), 255);
    strobe(0, 0, 1'b1, 0, 0);
    repeat (2) tick();
    chk("meter_decay1", int'(meter), 240);
    strobe(1000, -1000, 1'b1, 1000, -1000);
    repeat (2) tick();
    chk("meter_decay2", int'(meter), 225);
    repeat (5) tick();
    chk("meter_hold", int'(meter), 225);
    strobe(-131072, -131072, 1'b1, -131072, -131072);
    repeat (2) tick();
    chk("meter_neg_full", int'(meter), 255);
    drain();

    // Reset while a sample is in flight
    do_reset();
    mode = 4'b0101; step = DW'(4095);
    strobe(0, 0, 1'b1, 0, 0);
    strobe(0, 0, 1'b1, 4096, 4096);
    drain();
    chk("meter_before_rst", int'(meter), 8);
    strobe(0, 0, 1'b0, 0, 0);
    reset = 1'b1;
    tick();
    chk("cancel_valid", int'(out_valid), 0);
    tick();
    chk("cancel_valid2", int'(out_valid), 0);
    reset = 1'b0;
    chk("mid_rst_dac", int'(|dac_out), 0);
    chk("mid_rst_meter", int'(meter), 0);
    strobe(0, 0, 1'b1, 0, 0);
    strobe(0, 0, 1'b1, 4096, 4096);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
